// File: rtl/march_lr_bist_ctrl.sv
// March LR BIST controller for a single-port SRAM with asynchronous read.
// Issues one March operation per clock and records first-failure diagnostics.
//
// state  | meaning
// S_IDLE | waiting for start after reset
// S_RUN  | applying March LR, one op per cycle
// S_DONE | run finished; status held until next start
module march_lr_bist_ctrl #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 4,
    parameter int CNT_W        = 8,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act,
    output logic [CNT_W-1:0]  fail_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [2:0] LAST_ELEM = 3'd5;

    // Op descriptor {last op of element, write, background}.
    function automatic logic [2:0] op_decode(input logic [2:0] elem, input logic [2:0] op);
        logic [2:0] d;
        d = 3'b100;
        case (elem)
            3'd0: d = 3'b110;
            3'd1: d = (op == 3'd0) ? 3'b000 : 3'b111;
            3'd2: begin
                case (op)
                    3'd0:    d = 3'b001;
                    3'd1:    d = 3'b010;
                    3'd2:    d = 3'b000;
                    3'd3:    d = 3'b000;
                    default: d = 3'b111;
                endcase
            end
            3'd3: d = (op == 3'd0) ? 3'b001 : 3'b110;
            3'd4: begin
                case (op)
                    3'd0:    d = 3'b000;
                    3'd1:    d = 3'b011;
                    3'd2:    d = 3'b001;
                    3'd3:    d = 3'b001;
                    default: d = 3'b110;
                endcase
            end
            default: d = 3'b100;
        endcase
        return d;
    endfunction

    state_t            state;
    logic [2:0]        elem;
    logic [2:0]        op;

    logic [2:0]        cur_dec;
    logic [2:0]        nxt_dec;
    logic [2:0]        launch_dec;
    logic              elem_down;
    logic              addr_end;
    logic [2:0]        nxt_elem;
    logic [2:0]        nxt_op;
    logic [ADDR_W-1:0] nxt_addr;
    logic              run_end;
    logic              mismatch;

    always_comb begin
        cur_dec    = op_decode(elem, op);
        launch_dec = op_decode(3'd0, 3'd0);
        elem_down  = (elem == 3'd1);
        addr_end   = elem_down ? (mem_addr == {ADDR_W{1'b0}}) : (mem_addr == {ADDR_W{1'b1}});
        nxt_elem   = elem;
        nxt_op     = op + 3'd1;
        nxt_addr   = mem_addr;
        if (cur_dec[2]) begin
            nxt_op = 3'd0;
            if (addr_end) begin
                nxt_elem = elem + 3'd1;
                // only M1 runs downward, and it follows M0
                nxt_addr = (elem == 3'd0) ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
            end else if (elem_down) begin
                nxt_addr = mem_addr - ADDR_W'(1);
            end else begin
                nxt_addr = mem_addr + ADDR_W'(1);
            end
        end
        nxt_dec  = op_decode(nxt_elem, nxt_op);
        run_end  = cur_dec[2] && addr_end && (elem == LAST_ELEM);
        mismatch = (state == S_RUN) && !mem_we && (mem_dout != mem_din);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            elem       <= 3'd0;
            op         <= 3'd0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_din    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail       <= 1'b0;
            fail_addr  <= '0;
            fail_elem  <= 3'd0;
            fail_exp   <= '0;
            fail_act   <= '0;
            fail_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_RUN;
                        elem       <= 3'd0;
                        op         <= 3'd0;
                        mem_addr   <= '0;
                        mem_we     <= launch_dec[1];
                        mem_din    <= {DATA_W{launch_dec[0]}};
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        fail       <= 1'b0;
                        fail_addr  <= '0;
                        fail_elem  <= 3'd0;
                        fail_exp   <= '0;
                        fail_act   <= '0;
                        fail_count <= '0;
                    end
                end
                S_RUN: begin
                    if (mismatch) begin
                        if (fail_count != {CNT_W{1'b1}}) begin
                            fail_count <= fail_count + CNT_W'(1);
                        end
                        if (!fail) begin
                            fail      <= 1'b1;
                            fail_addr <= mem_addr;
                            fail_elem <= elem;
                            fail_exp  <= mem_din;
                            fail_act  <= mem_dout;
                        end
                    end
                    if (run_end || (STOP_ON_FAIL && mismatch)) begin
                        state    <= S_DONE;
                        elem     <= 3'd0;
                        op       <= 3'd0;
                        mem_addr <= '0;
                        mem_we   <= 1'b0;
                        mem_din  <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        pass     <= !(fail || mismatch);
                    end else begin
                        elem     <= nxt_elem;
                        op       <= nxt_op;
                        mem_addr <= nxt_addr;
                        mem_we   <= nxt_dec[1];
                        mem_din  <= {DATA_W{nxt_dec[0]}};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_march_lr_bist_ctrl.sv
// Scoreboard bench for march_lr_bist_ctrl: default, stop-on-fail and 2-bit-counter
// instances, each behind its own SRAM model, checked when done rises.
module tb_march_lr_bist_ctrl;

    typedef struct {
        string name;
        int    cycles;
        int    pass;
        int    cnt;
        int    addr;
        int    elem;
        int    fexp;
        int    fact;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_m, start_s, start_t;
    logic fault_m;
    bit   trace_en;

    logic [7:0] addr_m, addr_s, addr_t;
    logic       we_m, we_s, we_t;
    logic [3:0] din_m, din_s, din_t;
    logic [3:0] dout_m, dout_s, dout_t;
    logic       busy_m, busy_s, busy_t;
    logic       done_m, done_s, done_t;
    logic       pass_m, pass_s, pass_t;
    logic       fail_m, fail_s, fail_t;
    logic [7:0] faddr_m, faddr_s, faddr_t;
    logic [2:0] felem_m, felem_s, felem_t;
    logic [3:0] fexp_m, fexp_s, fexp_t;
    logic [3:0] fact_m, fact_s, fact_t;
    logic [7:0] cnt_m, cnt_s;
    logic [1:0] cnt_t;

    logic [3:0] mem_m [256];
    logic [3:0] mem_s [256];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_m    = 0;

    exp_t q_m[$];
    exp_t q_s[$];
    exp_t q_t[$];

    logic [31:0] seq0, seq255, seq128, exp_seq;
    logic [1:0]  march_ops [16];

    march_lr_bist_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_m),
        .mem_addr(addr_m), .mem_we(we_m), .mem_din(din_m), .mem_dout(dout_m),
        .busy(busy_m), .done(done_m), .pass(pass_m), .fail(fail_m),
        .fail_addr(faddr_m), .fail_elem(felem_m), .fail_exp(fexp_m),
        .fail_act(fact_m), .fail_count(cnt_m)
    );

    march_lr_bist_ctrl #(.STOP_ON_FAIL(1'b1)) u_stop (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .mem_addr(addr_s), .mem_we(we_s), .mem_din(din_s), .mem_dout(dout_s),
        .busy(busy_s), .done(done_s), .pass(pass_s), .fail(fail_s),
        .fail_addr(faddr_s), .fail_elem(felem_s), .fail_exp(fexp_s),
        .fail_act(fact_s), .fail_count(cnt_s)
    );

    march_lr_bist_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start_t),
        .mem_addr(addr_t), .mem_we(we_t), .mem_din(din_t), .mem_dout(dout_t),
        .busy(busy_t), .done(done_t), .pass(pass_t), .fail(fail_t),
        .fail_addr(faddr_t), .fail_elem(felem_t), .fail_exp(fexp_t),
        .fail_act(fact_t), .fail_count(cnt_t)
    );

    // SRAM models: bit2 of word 0x37 stuck at 1 when the fault is enabled
    always @(posedge clk) begin
        if (we_m) mem_m[addr_m] <= din_m;
        if (we_s) mem_s[addr_s] <= din_s;
    end
    assign dout_m = mem_m[addr_m] | ((fault_m && addr_m == 8'h37) ? 4'h4 : 4'h0);
    assign dout_s = mem_s[addr_s] | ((addr_s == 8'h37) ? 4'h4 : 4'h0);
    assign dout_t = 4'hA;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input int cyc, input int p, input int c,
                                input int a, input int el, input int ex, input int ac);
        exp_t e;
        e.name = n; e.cycles = cyc; e.pass = p; e.cnt = c;
        e.addr = a; e.elem = el; e.fexp = ex; e.fact = ac;
        return e;
    endfunction

    task automatic check_run(input exp_t e, input int cyc, input int busy, input int pass,
                             input int fail, input int cnt, input int addr, input int elem,
                             input int fexp, input int fact);
        chk({e.name, ".busy_cycles"}, cyc, e.cycles);
        chk({e.name, ".busy"}, busy, 0);
        chk({e.name, ".pass"}, pass, e.pass);
        chk({e.name, ".fail"}, fail, (e.pass != 0) ? 0 : 1);
        chk({e.name, ".fail_count"}, cnt, e.cnt);
        chk({e.name, ".fail_addr"}, addr, e.addr);
        chk({e.name, ".fail_elem"}, elem, e.elem);
        chk({e.name, ".fail_exp"}, fexp, e.fexp);
        chk({e.name, ".fail_act"}, fact, e.fact);
    endtask

    task automatic unexpected(input string who);
        n_checks++;
        n_fail++;
        $display("FAIL %s_unexpected_done: got done rising expected no pending run", who);
    endtask

    initial begin : mon_m
        int   cyc;
        bit   bq, dq;
        exp_t e;
        cyc = 0; bq = 0; dq = 0;
        forever begin
            @(negedge clk);
            if (busy_m && !bq) cyc = 0;
            if (busy_m) cyc++;
            cyc_m = cyc;
            if (trace_en && busy_m) begin
                if (addr_m == 8'd0)   seq0   = {seq0[29:0],   we_m, din_m == 4'hF};
                if (addr_m == 8'd255) seq255 = {seq255[29:0], we_m, din_m == 4'hF};
                if (addr_m == 8'd128) seq128 = {seq128[29:0], we_m, din_m == 4'hF};
            end
            if (done_m && !dq) begin
                if (q_m.size() == 0) unexpected("main");
                else begin
                    e = q_m.pop_front();
                    check_run(e, cyc, busy_m, pass_m, fail_m, cnt_m, faddr_m, felem_m, fexp_m, fact_m);
                end
            end
            bq = busy_m; dq = done_m;
        end
    end

    initial begin : mon_s
        int   cyc;
        bit   bq, dq;
        exp_t e;
        cyc = 0; bq = 0; dq = 0;
        forever begin
            @(negedge clk);
            if (busy_s && !bq) cyc = 0;
            if (busy_s) cyc++;
            if (done_s && !dq) begin
                if (q_s.size() == 0) unexpected("stop");
                else begin
                    e = q_s.pop_front();
                    check_run(e, cyc, busy_s, pass_s, fail_s, cnt_s, faddr_s, felem_s, fexp_s, fact_s);
                end
            end
            bq = busy_s; dq = done_s;
        end
    end

    initial begin : mon_t
        int   cyc;
        bit   bq, dq;
        exp_t e;
        cyc = 0; bq = 0; dq = 0;
        forever begin
            @(negedge clk);
            if (busy_t && !bq) cyc = 0;
            if (busy_t) cyc++;
            if (done_t && !dq) begin
                if (q_t.size() == 0) unexpected("sat");
                else begin
                    e = q_t.pop_front();
                    check_run(e, cyc, busy_t, pass_t, fail_t, cnt_t, faddr_t, felem_t, fexp_t, fact_t);
                end
            end
            bq = busy_t; dq = done_t;
        end
    end

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while ((q_m.size() + q_s.size() + q_t.size()) != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        if ((q_m.size() + q_s.size() + q_t.size()) != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got %0d runs pending after %0d cycles expected 0",
                     q_m.size() + q_s.size() + q_t.size(), limit);
            q_m.delete(); q_s.delete(); q_t.delete();
        end
    endtask

    task automatic pulse_m();
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; start_t = 1'b0;
        fault_m = 1'b0; trace_en = 1'b0;
        seq0 = '0; seq255 = '0; seq128 = '0;
        // w0 r0 w1 r1 w0 r0 r0 w1 r1 w0 r0 w1 r1 r1 w0 r0 as {we, bg}
        march_ops = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11,
                      2'b01, 2'b10, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b00};
        exp_seq = '0;
        for (int i = 0; i < 16; i++) exp_seq = {exp_seq[29:0], march_ops[i]};

        repeat (3) @(negedge clk);
        chk("reset.busy", busy_m, 0);
        chk("reset.done", done_m, 0);
        chk("reset.pass", pass_m, 0);
        chk("reset.mem_we", we_m, 0);
        chk("reset.mem_addr", addr_m, 0);
        chk("reset.mem_din", din_m, 0);
        chk("reset.fail_count", cnt_m, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // clean run on main, stuck-at with stop-on-fail, all-reads-fail saturation
        trace_en = 1'b1;
        q_m.push_back(mk("clean", 4096, 1, 0, 0, 0, 0, 0));
        q_s.push_back(mk("stop", 657, 0, 1, 8'h37, 1, 4'h0, 4'h4));
        q_t.push_back(mk("sat", 4096, 0, 3, 8'hFF, 1, 4'h0, 4'hA));
        start_m = 1'b1; start_s = 1'b1; start_t = 1'b1;
        @(negedge clk);
        start_m = 1'b0; start_s = 1'b0; start_t = 1'b0;
        wait_drain(5000);
        trace_en = 1'b0;
        chk("seq_addr0", seq0, exp_seq);
        chk("seq_addr255", seq255, exp_seq);
        chk("seq_addr128", seq128, exp_seq);

        fault_m = 1'b1;
        q_m.push_back(mk("stuck", 4096, 0, 5, 8'h37, 1, 4'h0, 4'h4));
        pulse_m();
        wait_drain(5000);

        // restart from DONE after a failing run, with a stray start mid-run
        fault_m = 1'b0;
        q_m.push_back(mk("ignore_start", 4096, 1, 0, 0, 0, 0, 0));
        pulse_m();
        chk("restart.done", done_m, 0);
        chk("restart.fail", fail_m, 0);
        chk("restart.fail_count", cnt_m, 0);
        chk("restart.fail_addr", faddr_m, 0);
        chk("restart.busy", busy_m, 1);
        repeat (1000) @(negedge clk);
        pulse_m();
        chk("midrun_start.busy", busy_m, 1);
        wait_drain(5000);
        q_m.push_back(mk("rerun", 4096, 1, 0, 0, 0, 0, 0));
        pulse_m();
        wait_drain(5000);

        // asynchronous reset while a write in M2 is on the bus
        pulse_m();
        for (int i = 0; i < 3000; i++) begin
            if (cyc_m > 1000 && we_m) break;
            @(negedge clk);
        end
        chk("abort.reached_m2_write", (cyc_m > 1000 && we_m) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.mem_we", we_m, 0);
        chk("abort.busy", busy_m, 0);
        chk("abort.mem_addr", addr_m, 0);
        chk("abort.mem_din", din_m, 0);
        chk("abort.done", done_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q_m.push_back(mk("post_reset", 4096, 1, 0, 0, 0, 0, 0));
        pulse_m();
        wait_drain(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
